// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared encodings for the data-memory controller and the core-side load/store decode.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_BAD = 2'b11} size_e;
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY, S_RESP} state_e;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sgn;
    } acc_t;

    // op[3] selects store, op[2] marks the unsigned loads, op[1:0]==3 is a word access
    function automatic acc_t op_decode(logic [5:0] op);
        acc_t a;
        a.we   = op[3];
        a.size = op[1:0] == 2'b11 ? SZ_WORD : op[1:0];
        a.sgn  = !op[2];
        return a;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bus between the core (master) and the data-memory controller (slave).
interface dmem_ctrl_if #(parameter int ADDR_W = 32) ();
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sgn;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              ack;
    logic [31:0]       rdata;
    logic              err;
    logic              init_busy;

    modport master (output req, we, size, sgn, addr, wdata, input ready, ack, rdata, err, init_busy);
    modport slave  (input req, we, size, sgn, addr, wdata, output ready, ack, rdata, err, init_busy);
endinterface

// File: rtl/dmem_align.sv
// dmem_align: byte-lane steering for sub-word stores and extraction/extension for sub-word loads.
module dmem_align
    import dmem_ctrl_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [1:0]  size_i,
    input  logic        sgn_i,
    input  logic [1:0]  lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);
    logic [1:0]  lane;
    logic        hi;
    logic [7:0]  b;
    logic [15:0] h;

    // lane[1] also picks the upper half for halfword accesses in either byte order
    always_comb begin
        lane       = BIG_ENDIAN != 0 ? ~lo_i : lo_i;
        hi         = lane[1];
        b          = rword_i[{lane, 3'b000} +: 8];
        h          = hi ? rword_i[31:16] : rword_i[15:0];
        be_o       = size_i == SZ_BYTE ? 4'b0001 << lane :
                     size_i == SZ_HALF ? (hi ? 4'b1100 : 4'b0011) :
                     size_i == SZ_WORD ? 4'b1111 : 4'b0000;
        wword_o    = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
                     size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o    = size_i == SZ_BYTE ? {{24{sgn_i & b[7]}}, b} :
                     size_i == SZ_HALF ? {{16{sgn_i & h[15]}}, h} : rword_i;
        misalign_o = (size_i == SZ_HALF && lo_i[0]) || (size_i == SZ_WORD && lo_i != 2'b00);
    end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle byte/half/word data memory with req/ready/ack handshake,
// fault detection and a one-word-per-cycle zero-fill sweep after reset.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = 32,
    parameter int LATENCY      = 1,
    parameter int CLEAR_ON_RST = 1,
    parameter int BIG_ENDIAN   = 1
) (
    input logic        CLK,
    input logic        RST,
    dmem_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        lat_q, lat_d;
    logic              we_q, sgn_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [31:0]       mem_q [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rword, wword, rd_ext, bmask;
    logic [3:0]        be;
    logic              misalign, fault, fire;

    assign idx   = addr_q[IDX_W+1:2];
    assign rword = mem_q[idx];

    dmem_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .size_i     (size_q),
        .sgn_i      (sgn_q),
        .lo_i       (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rword_i    (rword),
        .be_o       (be),
        .wword_o    (wword),
        .rdata_o    (rd_ext),
        .misalign_o (misalign)
    );

    // Every access, LATENCY=1 included, spends LATENCY cycles in BUSY so the
    // store commit and ack always land LATENCY edges after acceptance.
    always_comb begin
        fault   = size_q == SZ_BAD || misalign || (addr_q >> (IDX_W + 2)) != '0;
        fire    = state_q == S_BUSY && lat_q == 2'd0;
        bmask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        unique case (state_q)
            S_CLEAR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == IDX_W'(DEPTH - 1) ? S_IDLE : S_CLEAR;
            end
            S_IDLE: begin
                state_d = bus.req ? S_BUSY : S_IDLE;
                lat_d   = bus.req ? 2'(LATENCY - 1) : lat_q;
            end
            S_BUSY: begin
                lat_d   = lat_q - 1'b1;
                state_d = lat_q == 2'd0 ? S_RESP : S_BUSY;
            end
            S_RESP: state_d = S_IDLE;
        endcase
    end

    assign bus.ready     = state_q == S_IDLE;
    assign bus.ack       = state_q == S_RESP;
    assign bus.err       = bus.ack && fault;
    assign bus.rdata     = rdata_q;
    assign bus.init_busy = state_q == S_CLEAR;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= CLEAR_ON_RST != 0 ? S_CLEAR : S_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            if (fire && (fault || !we_q))
                rdata_q <= fault ? '0 : rd_ext;
        end
    end

    always_ff @(posedge CLK) begin
        if (state_q == S_IDLE && bus.req) begin
            we_q    <= bus.we;
            size_q  <= bus.size;
            sgn_q   <= bus.sgn;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    // Reset suppresses both the sweep write and any pending store commit.
    always_ff @(posedge CLK) begin
        if (!RST && state_q == S_CLEAR)
            mem_q[cnt_q] <= '0;
        else if (!RST && fire && we_q && !fault)
            mem_q[idx] <= (rword & ~bmask) | (wword & bmask);
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized accesses checked against a byte-arithmetic memory model.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int DEPTH = 16;
    localparam int LAT   = 3;
    localparam int BE    = 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    dmem_ctrl_if #(.ADDR_W(32)) bus ();

    dmem_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT), .CLEAR_ON_RST(1), .BIG_ENDIAN(BE)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] mdl_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: memory as bytes placed by offset arithmetic, faults from address/size rules.
    task automatic predict(input logic w, input logic [1:0] sz, input logic s,
                           input logic [31:0] a, input logic [31:0] wd, output logic e);
        int          nb, off, sh, ix;
        logic [63:0] full;
        logic [31:0] m, v;
        nb  = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        off = int'(a % 4);
        e   = sz == 2'd3 || (a % nb) != 0 || (a / 4) >= DEPTH;
        if (e) begin
            mdl_rd = '0;
        end else begin
            ix   = int'(a / 4);
            sh   = BE != 0 ? (4 - off - nb) * 8 : off * 8;
            full = (64'd1 << (8 * nb)) - 64'd1;
            m    = full[31:0] << sh;
            if (w) begin
                mdl[ix] = (mdl[ix] & ~m) | ((wd << sh) & m);
            end else begin
                v = (mdl[ix] >> sh) & full[31:0];
                if (s && nb < 4 && v[8*nb-1]) v = v | ~full[31:0];
                mdl_rd = v;
            end
        end
    endtask

    task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic s,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold,
                          output logic [31:0] got);
        int         n;
        logic [7:0] ack_pat, rdy_pat;
        logic       e_got, e_exp;
        n = 0;
        while (!bus.ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.ready) chk({tag, "/ready_timeout"}, 32'(bus.ready), 32'd1);
        predict(w, sz, s, a, wd, e_exp);
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sgn = s; bus.addr = a; bus.wdata = wd;
        ack_pat = '0; rdy_pat = '0; got = '0; e_got = 1'b0;
        @(negedge CLK);
        for (int i = 0; i <= LAT + 1; i++) begin
            ack_pat[i] = bus.ack;
            rdy_pat[i] = bus.ready;
            if (i == LAT) begin
                got   = bus.rdata;
                e_got = bus.err;
            end
            if (!hold || i == LAT + 1) bus.req = 1'b0;
            if (i <= LAT) @(negedge CLK);
        end
        chk({tag, "/ack_timing"}, 32'(ack_pat), 32'(1 << LAT));
        chk({tag, "/ready_timing"}, 32'(rdy_pat), 32'(1 << (LAT + 1)));
        chk({tag, "/err"}, 32'(e_got), 32'(e_exp));
        chk({tag, "/rdata"}, got, mdl_rd);
    endtask

    logic [5:0] ops [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

    initial begin
        int          n;
        logic        bad, seen;
        logic [31:0] r;
        acc_t        ac;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        mdl_rd = '0;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = SZ_WORD; bus.sgn = 1'b0; bus.addr = '0; bus.wdata = '0;

        repeat (2) @(negedge CLK);
        chk("rst/ready", 32'(bus.ready), 32'd0);
        chk("rst/ack", 32'(bus.ack), 32'd0);
        chk("rst/err", 32'(bus.err), 32'd0);
        chk("rst/rdata", bus.rdata, 32'd0);
        chk("rst/init_busy", 32'(bus.init_busy), 32'd1);
        RST = 1'b0;
        n = 0; bad = 1'b0;
        while (bus.init_busy && n < 100) begin
            bad |= bus.ready;
            n++;
            @(negedge CLK);
        end
        chk("clear/len", 32'(n), 32'(DEPTH));
        chk("clear/ready_low", 32'(bad), 32'd0);

        access("lw3c", 1'b0, SZ_WORD, 1'b0, 32'h3C, 32'h0, 1'b0, r);
        chk("lw3c/zero", r, 32'h0);

        access("sw8", 1'b1, SZ_WORD, 1'b0, 32'h8, 32'h11223344, 1'b0, r);
        access("sb9", 1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h000000AA, 1'b0, r);
        access("lw8", 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b0, r);
        chk("lw8/const", r, 32'h11AA3344);
        access("lb9", 1'b0, SZ_BYTE, 1'b1, 32'h9, 32'h0, 1'b0, r);
        chk("lb9/const", r, 32'hFFFFFFAA);
        access("lbu9", 1'b0, SZ_BYTE, 1'b0, 32'h9, 32'h0, 1'b0, r);
        chk("lbu9/const", r, 32'h000000AA);
        access("lha", 1'b0, SZ_HALF, 1'b1, 32'hA, 32'h0, 1'b0, r);
        chk("lha/const", r, 32'h00003344);

        access("hold", 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b1, r);

        access("lw6", 1'b0, SZ_WORD, 1'b0, 32'h6, 32'h0, 1'b0, r);
        access("sh3", 1'b1, SZ_HALF, 1'b0, 32'h3, 32'hBEEF, 1'b0, r);
        access("lw0_after_sh3", 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, r);
        access("sw_oor", 1'b1, SZ_WORD, 1'b0, 32'(DEPTH * 4), 32'hCAFEF00D, 1'b0, r);
        access("lw0_after_oor", 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, r);
        chk("lw0_after_oor/const", r, 32'h0);

        access("b2b_sw", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h5A5AC3C3, 1'b0, r);
        access("b2b_lw", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, r);
        chk("b2b_lw/const", r, 32'h5A5AC3C3);

        for (int i = 0; i < 200; i++) begin
            ac = op_decode(ops[$urandom_range(0, 7)]);
            if ($urandom_range(0, 9) == 0) ac.size = SZ_BAD;
            access($sformatf("rnd%0d", i), ac.we, ac.size, ac.sgn,
                   32'($urandom_range(0, DEPTH * 4 + 7)), $urandom, 1'b0, r);
        end

        bus.req = 1'b1; bus.we = 1'b1; bus.size = SZ_WORD; bus.sgn = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'hDEADBEEF;
        @(negedge CLK);
        bus.req = 1'b0;
        seen = bus.ack;
        @(negedge CLK);
        seen |= bus.ack;
        RST = 1'b1;
        @(negedge CLK);
        seen |= bus.ack;
        RST = 1'b0;
        chk("midrst/init_busy", 32'(bus.init_busy), 32'd1);
        chk("midrst/rdata", bus.rdata, 32'd0);
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        mdl_rd = '0;
        n = 0;
        while (bus.init_busy && n < 100) begin
            seen |= bus.ack;
            n++;
            @(negedge CLK);
        end
        chk("midrst/clear_len", 32'(n), 32'(DEPTH));
        chk("midrst/no_ack", 32'(seen), 32'd0);
        access("midrst_lw0", 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, r);
        chk("midrst_lw0/const", r, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
